// File: rtl/parking_fee_unit.sv
// Ticketing and payment stage for the car park: timestamps entries, bills exits
// per started period (capped), collects coins and pulses pay / refund.
module parking_fee_unit #(
  parameter int PMAX    = 5,
  parameter int IDW     = 3,
  parameter int TW      = 16,
  parameter int PERIOD  = 60,
  parameter int RATE    = 2,
  parameter int MAX_FEE = 50,
  parameter int FEE_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             entry,
  output logic             entry_ack,
  output logic [IDW-1:0]   entry_id,
  output logic             entry_err,
  output logic             entry_full,
  output logic [IDW:0]     occupied,
  input  logic             exit_req,
  input  logic [IDW-1:0]   exit_id,
  output logic             err,
  output logic             busy,
  output logic [FEE_W-1:0] cost,
  output logic             cost_valid,
  input  logic             coin_valid,
  input  logic [FEE_W-1:0] coin_value,
  input  logic             cancel,
  output logic [FEE_W-1:0] paid_sum,
  output logic             pay,
  output logic [FEE_W-1:0] change,
  output logic             refund,
  output logic [FEE_W-1:0] refund_value
);

  localparam logic [TW-1:0]    LP_PERIOD  = TW'(PERIOD);
  localparam logic [FEE_W:0]   LP_RATE    = (FEE_W+1)'(RATE);
  localparam logic [FEE_W:0]   LP_MAX_W   = (FEE_W+1)'(MAX_FEE);
  localparam logic [FEE_W-1:0] LP_MAX_FEE = FEE_W'(MAX_FEE);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  function automatic logic [IDW:0] f_popcount(input logic [PMAX-1:0] v);
    logic [IDW:0] c;
    c = '0;
    for (int i = 0; i < PMAX; i++) begin
      c = c + {{IDW{1'b0}}, v[i]};
    end
    return c;
  endfunction

  state_t            r_state;
  logic [TW-1:0]     r_now;
  logic [PMAX-1:0]   r_valid;
  logic [TW-1:0]     r_ts [PMAX];
  logic [IDW-1:0]    r_id;
  logic [TW-1:0]     r_rem;
  logic              r_calc_done;
  logic [FEE_W-1:0]  r_cost;
  logic [FEE_W-1:0]  r_paid;
  logic              r_cost_valid;
  logic              r_busy;
  logic              r_err;
  logic              r_pay;
  logic [FEE_W-1:0]  r_change;
  logic              r_refund;
  logic [FEE_W-1:0]  r_refund_value;
  logic              r_entry_ack;
  logic [IDW-1:0]    r_entry_id;
  logic              r_entry_err;
  logic              r_full;
  logic [IDW:0]      r_occ;

  logic              w_free_found;
  logic [IDW-1:0]    w_free_id;
  logic              w_exit_ok;
  logic [TW-1:0]     w_ts_sel;
  logic              w_paid_enough;
  logic              w_release;
  logic [PMAX-1:0]   w_valid_nxt;
  logic [FEE_W:0]    w_cost_sum;
  logic [FEE_W-1:0]  w_cost_nxt;
  logic [TW-1:0]     w_rem_nxt;
  logic [FEE_W:0]    w_coin_sum;
  logic [FEE_W-1:0]  w_paid_sat;

  // Lowest-index free slot, and validity / timestamp of the presented exit ticket.
  always_comb begin
    w_free_found = 1'b0;
    w_free_id    = '0;
    w_exit_ok    = 1'b0;
    w_ts_sel     = '0;
    for (int i = PMAX - 1; i >= 0; i--) begin
      if (!r_valid[i]) begin
        w_free_found = 1'b1;
        w_free_id    = IDW'(i);
      end else begin
        w_free_found = w_free_found;
      end
    end
    for (int i = 0; i < PMAX; i++) begin
      if (exit_id == IDW'(i)) begin
        w_exit_ok = r_valid[i];
        w_ts_sel  = r_ts[i];
      end else begin
        w_exit_ok = w_exit_ok;
      end
    end
  end

  // Fee iteration, coin accumulation and the slot-valid vector for the next edge.
  always_comb begin
    w_cost_sum    = {1'b0, r_cost} + LP_RATE;
    w_cost_nxt    = (w_cost_sum >= LP_MAX_W) ? LP_MAX_FEE : w_cost_sum[FEE_W-1:0];
    w_rem_nxt     = (r_rem > LP_PERIOD) ? (r_rem - LP_PERIOD) : '0;
    w_coin_sum    = {1'b0, r_paid} + {1'b0, coin_value};
    w_paid_sat    = w_coin_sum[FEE_W] ? '1 : w_coin_sum[FEE_W-1:0];
    w_paid_enough = (r_paid >= r_cost);
    // cancel takes precedence, so a cancelled cycle never releases the ticket
    w_release     = (r_state == S_WAIT) && !cancel && w_paid_enough;
    w_valid_nxt   = r_valid;
    for (int i = 0; i < PMAX; i++) begin
      if (w_release && (r_id == IDW'(i))) begin
        w_valid_nxt[i] = 1'b0;
      end else begin
        w_valid_nxt[i] = w_valid_nxt[i];
      end
      if (entry && w_free_found && (w_free_id == IDW'(i))) begin
        w_valid_nxt[i] = 1'b1;
      end else begin
        w_valid_nxt[i] = w_valid_nxt[i];
      end
    end
  end

  // Free-running timestamp, advanced by the time-base strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_now <= '0;
    end else if (tick) begin
      r_now <= r_now + {{(TW-1){1'b0}}, 1'b1};
    end
  end

  // Ticket slots: allocation on entry, release on pay, occupancy status.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid     <= '0;
      r_entry_ack <= 1'b0;
      r_entry_id  <= '0;
      r_entry_err <= 1'b0;
      r_full      <= 1'b0;
      r_occ       <= '0;
      for (int i = 0; i < PMAX; i++) begin
        r_ts[i] <= '0;
      end
    end else begin
      r_entry_ack <= 1'b0;
      r_entry_err <= 1'b0;
      if (entry) begin
        if (w_free_found) begin
          r_entry_ack <= 1'b1;
          r_entry_id  <= w_free_id;
          for (int i = 0; i < PMAX; i++) begin
            if (w_free_id == IDW'(i)) begin
              r_ts[i] <= r_now;
            end
          end
        end else begin
          r_entry_err <= 1'b1;
        end
      end
      r_valid <= w_valid_nxt;
      r_full  <= &w_valid_nxt;
      r_occ   <= f_popcount(w_valid_nxt);
    end
  end

  // Exit / payment FSM with registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= S_IDLE;
      r_id           <= '0;
      r_rem          <= '0;
      r_calc_done    <= 1'b0;
      r_cost         <= '0;
      r_paid         <= '0;
      r_cost_valid   <= 1'b0;
      r_busy         <= 1'b0;
      r_err          <= 1'b0;
      r_pay          <= 1'b0;
      r_change       <= '0;
      r_refund       <= 1'b0;
      r_refund_value <= '0;
    end else begin
      r_err    <= 1'b0;
      r_pay    <= 1'b0;
      r_refund <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (exit_req) begin
            if (w_exit_ok) begin
              r_id        <= exit_id;
              r_rem       <= r_now - w_ts_sel;
              r_cost      <= '0;
              r_paid      <= '0;
              r_calc_done <= 1'b0;
              r_busy      <= 1'b1;
              r_state     <= S_CALC;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        S_CALC: begin
          r_err <= exit_req;
          // one settle cycle after the final iteration before the fee is published
          if (r_calc_done) begin
            r_cost_valid <= 1'b1;
            r_state      <= S_WAIT;
          end else begin
            r_cost <= w_cost_nxt;
            r_rem  <= w_rem_nxt;
            if ((w_rem_nxt == '0) || (w_cost_nxt == LP_MAX_FEE)) begin
              r_calc_done <= 1'b1;
            end
          end
        end
        S_WAIT: begin
          r_err <= exit_req;
          if (cancel) begin
            r_refund       <= 1'b1;
            r_refund_value <= r_paid;
            r_paid         <= '0;
            r_cost_valid   <= 1'b0;
            r_busy         <= 1'b0;
            r_state        <= S_IDLE;
          end else if (w_paid_enough) begin
            r_pay        <= 1'b1;
            r_change     <= r_paid - r_cost;
            r_cost_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_state      <= S_IDLE;
          end else if (coin_valid) begin
            r_paid <= w_paid_sat;
          end
        end
        default: begin
          r_cost_valid <= 1'b0;
          r_busy       <= 1'b0;
          r_state      <= S_IDLE;
        end
      endcase
    end
  end

  assign entry_ack    = r_entry_ack;
  assign entry_id     = r_entry_id;
  assign entry_err    = r_entry_err;
  assign entry_full   = r_full;
  assign occupied     = r_occ;
  assign err          = r_err;
  assign busy         = r_busy;
  assign cost         = r_cost;
  assign cost_valid   = r_cost_valid;
  assign paid_sum     = r_paid;
  assign pay          = r_pay;
  assign change       = r_change;
  assign refund       = r_refund;
  assign refund_value = r_refund_value;

endmodule
